// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce.
// Strobes one active-low column per slot; reports accepted presses.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_N     = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t        state_q;
  logic [3:0]    s1_q;
  logic [3:0]    s2_q;
  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic [1:0]    ci_q;
  logic [3:0]    cols_q;
  logic [1:0]    cr_q;
  logic [CW-1:0] mc_q;
  logic [CW-1:0] rc_q;
  logic [3:0]    code_q;
  logic          valid_q;
  logic          down_q;

  logic          sample;
  logic          any_low;
  logic [1:0]    pick_row;
  logic          cand_low;
  logic [CW-1:0] mc_inc;
  logic [CW-1:0] rc_inc;

  // Two-flop synchronizer; idle rows read high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 4'hF;
      s2_q <= 4'hF;
    end else begin
      s1_q <= rows;
      s2_q <= s1_q;
    end
  end

  // Free-running slot divider; its last count is the sample edge.
  always_comb begin
    div_d = div_q + DW'(1);
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign sample = (div_q == DIV_LAST);

  // Lowest-index low row wins when several rows are low.
  always_comb begin
    pick_row = 2'd0;
    if (!s2_q[0]) begin
      pick_row = 2'd0;
    end else if (!s2_q[1]) begin
      pick_row = 2'd1;
    end else if (!s2_q[2]) begin
      pick_row = 2'd2;
    end else if (!s2_q[3]) begin
      pick_row = 2'd3;
    end
  end

  assign any_low  = ~&s2_q;
  assign cand_low = ~s2_q[cr_q];
  assign mc_inc   = mc_q + CNT_ONE;
  assign rc_inc   = rc_q + CNT_ONE;

  // Scan / debounce / held state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      ci_q    <= 2'd0;
      cols_q  <= 4'b1110;
      cr_q    <= 2'd0;
      mc_q    <= '0;
      rc_q    <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (sample) begin
        case (state_q)
          SCAN: begin
            if (any_low) begin
              cr_q <= pick_row;
              mc_q <= CNT_ONE;
              if (DEBOUNCE_SCANS == 1) begin
                code_q  <= {pick_row, ci_q};
                valid_q <= 1'b1;
                down_q  <= 1'b1;
                mc_q    <= '0;
                rc_q    <= '0;
                state_q <= HELD;
              end else begin
                state_q <= DEBOUNCE;
              end
            end else begin
              ci_q   <= ci_q + 2'd1;
              cols_q <= {cols_q[2:0], cols_q[3]};
            end
          end
          DEBOUNCE: begin
            if (cand_low) begin
              if (mc_inc == DB_N) begin
                code_q  <= {cr_q, ci_q};
                valid_q <= 1'b1;
                down_q  <= 1'b1;
                mc_q    <= '0;
                rc_q    <= '0;
                state_q <= HELD;
              end else begin
                mc_q <= mc_inc;
              end
            end else begin
              mc_q    <= '0;
              ci_q    <= ci_q + 2'd1;
              cols_q  <= {cols_q[2:0], cols_q[3]};
              state_q <= SCAN;
            end
          end
          HELD: begin
            if (!cand_low) begin
              if (rc_inc == DB_N) begin
                down_q  <= 1'b0;
                rc_q    <= '0;
                ci_q    <= ci_q + 2'd1;
                cols_q  <= {cols_q[2:0], cols_q[3]};
                state_q <= SCAN;
              end else begin
                rc_q <= rc_inc;
              end
            end else begin
              rc_q <= '0;
            end
          end
          default: begin
            state_q <= SCAN;
          end
        endcase
      end
    end
  end

  assign cols      = cols_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench with a switch-matrix keypad model.
// Instance a: SCAN_DIV=4, DEBOUNCE_SCANS=3; instance b: DEBOUNCE_SCANS=1.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        rst_b;
  logic [3:0]  rows_a;
  logic [3:0]  rows_b;
  logic [3:0]  cols_a;
  logic [3:0]  cols_b;
  logic [3:0]  code_a;
  logic [3:0]  code_b;
  logic        kv_a;
  logic        kv_b;
  logic        kd_a;
  logic        kd_b;
  logic [15:0] keys_a;
  logic [15:0] keys_b;

  int checks  = 0;
  int errors  = 0;
  int pulse_a = 0;
  int pulse_b = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .rows(rows_a),
    .cols(cols_a),
    .key_code(code_a),
    .key_valid(kv_a),
    .key_down(kd_a)
  );

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(1)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .rows(rows_b),
    .cols(cols_b),
    .key_code(code_b),
    .key_valid(kv_b),
    .key_down(kd_b)
  );

  // keys[r*4+c] closed pulls row r low while column c is strobed.
  always_comb begin
    rows_a = 4'hF;
    rows_b = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if ((keys_a[r*4 +: 4] & ~cols_a) != 4'h0) rows_a[r] = 1'b0;
      if ((keys_b[r*4 +: 4] & ~cols_b) != 4'h0) rows_b[r] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (kv_a === 1'b1) pulse_a <= pulse_a + 1;
    if (kv_b === 1'b1) pulse_b <= pulse_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    keys_a = 16'h0;
    keys_b = 16'h0;
    step(2);
    chk("rst_cols", cols_a, 4'b1110);
    chk("rst_code", code_a, 4'h0);
    chk("rst_valid", kv_a, 1'b0);
    chk("rst_down", kd_a, 1'b0);
    chk("rst_cols_b", cols_b, 4'b1110);

    rst_a = 1'b0;
    step(6);
    chk("scan_pre_rst", cols_a, 4'b1101);
    rst_a = 1'b1;
    #1;
    chk("rst_mid_cols", cols_a, 4'b1110);
    chk("rst_mid_down", kd_a, 1'b0);
    step(1);
    rst_a = 1'b0;

    step(3);
    chk("scan_c0", cols_a, 4'b1110);
    step(1);
    chk("scan_c1", cols_a, 4'b1101);
    step(4);
    chk("scan_c2", cols_a, 4'b1011);
    step(4);
    chk("scan_c3", cols_a, 4'b0111);
    step(4);
    chk("scan_wrap", cols_a, 4'b1110);

    keys_a[9] = 1'b1;
    step(15);
    chk("press_pre_valid", kv_a, 1'b0);
    chk("press_pre_down", kd_a, 1'b0);
    step(1);
    chk("press_valid", kv_a, 1'b1);
    chk("press_code", code_a, 4'h9);
    chk("press_down", kd_a, 1'b1);
    step(1);
    chk("press_pulse_end", kv_a, 1'b0);
    chk("press_hold_down", kd_a, 1'b1);

    keys_a[3] = 1'b1;
    step(400);
    chk("hold_down", kd_a, 1'b1);
    chk("hold_pulses", pulse_a, 1);
    chk("hold_cols", cols_a, 4'b1101);

    keys_a = 16'h0;
    step(10);
    chk("rel_pre_down", kd_a, 1'b1);
    step(1);
    chk("rel_down", kd_a, 1'b0);
    chk("rel_cols", cols_a, 4'b1011);
    chk("rel_code_kept", code_a, 4'h9);

    keys_a[6] = 1'b1;
    step(8);
    keys_a[6] = 1'b0;
    step(4);
    chk("bounce1_cols", cols_a, 4'b0111);
    chk("bounce1_down", kd_a, 1'b0);
    keys_a[6] = 1'b1;
    step(20);
    keys_a[6] = 1'b0;
    step(3);
    chk("bounce2_held_col", cols_a, 4'b1011);
    step(1);
    chk("bounce2_cols", cols_a, 4'b0111);
    chk("bounce2_down", kd_a, 1'b0);
    chk("bounce_pulses", pulse_a, 1);
    chk("bounce_code", code_a, 4'h9);

    keys_a[4]  = 1'b1;
    keys_a[12] = 1'b1;
    step(15);
    chk("multi_pre_valid", kv_a, 1'b0);
    step(1);
    chk("multi_valid", kv_a, 1'b1);
    chk("multi_code", code_a, 4'h4);
    chk("multi_down", kd_a, 1'b1);
    keys_a = 16'h0;
    step(12);
    chk("multi_rel_down", kd_a, 1'b0);
    chk("multi_rel_cols", cols_a, 4'b1101);
    chk("multi_pulses", pulse_a, 2);

    keys_b[15] = 1'b1;
    rst_b = 1'b0;
    step(15);
    chk("db1_cols", cols_b, 4'b0111);
    chk("db1_pre_valid", kv_b, 1'b0);
    step(1);
    chk("db1_valid", kv_b, 1'b1);
    chk("db1_code", code_b, 4'hF);
    chk("db1_down", kd_b, 1'b1);
    step(1);
    chk("db1_pulse_end", kv_b, 1'b0);
    step(4);
    chk("db1_hold_down", kd_b, 1'b1);
    chk("db1_pulses", pulse_b, 1);
    rst_b = 1'b1;
    #1;
    chk("db1_rst_down", kd_b, 1'b0);
    chk("db1_rst_cols", cols_b, 4'b1110);
    chk("db1_rst_code", code_b, 4'h0);
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad and reports debounced key presses as a 4-bit code with a one-cycle valid strobe. It is the input-side counterpart of the board's multiplexed seven-segment display driver. It strobes one column low at a time, samples the four row lines, debounces, and holds off repeats until release. Its key_code/key_valid outputs feed the digit-entry logic that ultimately supplies the display's segment inputs.

## Interface
- SCAN_DIV, default 50000: clk cycles per column slot; legal range ≥ 4.
- DEBOUNCE_SCANS, default 20: consecutive matching samples required for press and for release; legal range ≥ 1.
- clk  input  1  system clock.
- rst  input  1  reset. One clock; reset is asynchronous and active-high.
- rows  input  4  keypad row lines, active-low (externally pulled up), asynchronous to clk.
- cols  output  4  column strobes, active-low, exactly one bit low at all times.
- key_code  output  4  {row_index[1:0], col_index[1:0]} of the last accepted key.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_down  output  1  level, high from press acceptance until release acceptance.

## Operation
- rows passes through a 2-flop synchronizer before any use.
- Divider `div` counts 0..SCAN_DIV-1 and wraps. It is free-running in all states.
- Sample edge: the cycle where `div == SCAN_DIV-1`. All row evaluation happens only on sample edges.
- Column index `ci` drives cols as ~(1 << ci).
- Row pick: the lowest-index synchronized row that reads 0. Multiple rows low resolves to the lowest row.
- The FSM has three states: SCAN, DEBOUNCE, HELD.
- SCAN:
  - At a sample edge with no row low, `ci` increments mod 4 (3 wraps to 0).
  - At a sample edge with any row low, capture candidate row `cr` and the current `ci`, set match count `mc` = 1, and hold `ci`.
  - If DEBOUNCE_SCANS == 1, accept immediately. Otherwise go to DEBOUNCE.
- DEBOUNCE (`ci` held):
  - At each sample edge, if row `cr` reads 0 (other rows ignored), increment `mc`.
  - When `mc` reaches DEBOUNCE_SCANS, accept.
  - If row `cr` reads 1, abandon: `mc` = 0, `ci` increments mod 4, return to SCAN. No output changes.
- Accept:
  - key_code ← {cr, ci}.
  - key_valid = 1 for one cycle.
  - key_down ← 1.
  - Release count `rc` ← 0, go to HELD.
- HELD (`ci` held):
  - At each sample edge, if row `cr` reads 1, increment `rc`; if it reads 0, `rc` ← 0.
  - When `rc` reaches DEBOUNCE_SCANS: key_down ← 0, `ci` increments mod 4, return to SCAN.
  - Other keys pressed meanwhile are ignored (no rollover).
- key_code holds its value until the next accept. It does not clear on release.
- Counter widths: `div` is $clog2(SCAN_DIV) bits; `mc`/`rc` are $clog2(DEBOUNCE_SCANS+1) bits. Counters saturate by construction, never wrap.

## Timing
- Reset values (async, immediate):
  - cols = 4'b1110, key_code = 4'h0, key_valid = 0, key_down = 0.
  - State SCAN, `div` = `ci` = `mc` = `rc` = 0.
  - Synchronizer flops = 4'b1111.
- Deassertion of rst is synchronous to clk. The first sample edge occurs SCAN_DIV cycles after deassertion.
- Row input to sampled value: 2 cycles of synchronizer latency. A column is settled for SCAN_DIV-1 cycles before it is sampled, which is why SCAN_DIV ≥ 4.
- Press latency: key_valid and key_down rise 1 cycle after the sample edge that produces the DEBOUNCE_SCANS-th match. This is (DEBOUNCE_SCANS-1)*SCAN_DIV + 1 cycles after the detecting sample edge.
- key_code updates on the same cycle key_valid rises.
- key_valid is high for exactly 1 cycle per press, regardless of hold duration.
- Release latency: key_down falls 1 cycle after the sample edge producing the DEBOUNCE_SCANS-th consecutive high sample.
- The column advances on the cycle after a sample edge. A sample and a column change never occur in the same cycle's evaluation.
- Reset mid-DEBOUNCE or mid-HELD: no key_valid pulse is emitted, key_down clears immediately, and scanning restarts at column 0.

## Test plan
- Reset: assert rst mid-scan → cols = 4'b1110, key_code = 0, key_valid = 0, key_down = 0 immediately. After release of rst, cols steps through 1110 → 1101 → 1011 → 0111 → 1110 every SCAN_DIV cycles.
- Clean press (SCAN_DIV=4, DEBOUNCE_SCANS=3), key at row 2 / col 1, modeled as rows[2] = 0 only while cols[1] = 0 → exactly one key_valid pulse with key_code = 4'h9. key_down stays high while held and falls 3 samples after release.
- Bounce: hold the key for 2 samples, release for 1, repeat → no key_valid, key_down stays 0, and scanning resumes with the next column.
- Long hold (100 samples) → exactly one key_valid pulse. Pressing a second key (row 0 / col 3) during the hold produces no pulse.
- Simultaneous rows: rows 1 and 3 low on col 0 → key_code = 4'h4.
- DEBOUNCE_SCANS=1 with a key at row 3 / col 3 → key_valid rises 1 cycle after the first sample edge where cols = 4'b0111, with key_code = 4'hF. Asserting rst during HELD drops key_down within the same cycle.
